// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory_controller port between NREQ bus masters.
// Each grant runs one read or write with address, data and enable held for ACCESS_CYCLES cycles, then a one-cycle ack.
module mem_arbiter #(
    parameter int NREQ          = 3,
    parameter int ACCESS_CYCLES = 4,
    parameter int AW            = 16,
    parameter int DW            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_mode,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              mem_read_en,
    output logic              mem_write_en
);

    // Handshake: a requester holds req/we/addr/wdata until it sees its one-cycle ack,
    // then drops req on the edge ending that cycle; req is only sampled in IDLE.

    localparam int LW = $clog2(NREQ);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] eligible;
    logic [LW-1:0]   pick;
    logic [LW-1:0]   cand;
    logic            found;
    int              idx;

    // Walk from the farthest candidate back to last+1 so the nearest eligible index wins.
    always_comb begin
        eligible = boot_mode ? {{(NREQ-1){1'b0}}, req[0]} : req;
        pick     = last;
        found    = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx  = (int'(last) + k) % NREQ;
            cand = LW'(idx);
            if (eligible[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last         <= LW'(NREQ - 1);
            cnt          <= '0;
            ack          <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        last         <= pick;
                        grant        <= NREQ'(1) << pick;
                        mem_addr     <= addr[int'(pick)*AW +: AW];
                        mem_wdata    <= wdata[int'(pick)*DW +: DW];
                        mem_write_en <= we[pick];
                        mem_read_en  <= ~we[pick];
                        cnt          <= CW'(ACCESS_CYCLES - 1);
                        busy         <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (mem_read_en) begin
                            rdata <= mem_rdata;
                        end
                        mem_read_en  <= 1'b0;
                        mem_write_en <= 1'b0;
                        ack          <= grant;
                        state        <= ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: boot restriction, reads/writes, round-robin order,
// asynchronous abort, boot_mode release and back-to-back service of one requester.
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AC   = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              boot_mode = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   we = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_read_en;
    logic              mem_write_en;

    int checks = 0;
    int errors = 0;

    // One-entry memory model: returns the last written word at its address, else addr ^ 16'h5A5A.
    logic [AW-1:0] wr_addr = 16'hFFFF;
    logic [DW-1:0] wr_data = 16'h0000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_addr == wr_addr) ? wr_data : (mem_addr ^ 16'h5A5A);

    mem_arbiter #(.NREQ(NREQ), .ACCESS_CYCLES(AC), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .boot_mode(boot_mode), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .ack(ack), .grant(grant), .rdata(rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]           = w;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin errors++; $display("FAIL reset_en: got rd=%b wr=%b expected 0 0", mem_read_en, mem_write_en); end
        checks++; if (mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0000 0000", mem_addr, mem_wdata); end
        checks++; if (rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
        rst = 1'b1;
    endtask

    task automatic test_boot_mode();
        int wen = 0;
        int last_wen = -1;
        int acks = 0;
        int ack_cyc = -1;
        int bad = 0;
        int wbad = 0;
        boot_mode = 1'b1;
        set_port(0, 1'b1, 16'h0010, 16'hBEEF);
        set_port(1, 1'b0, 16'h0010, 16'h0000);
        set_port(2, 1'b1, 16'h0030, 16'h1111);
        req = 3'b111;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (grant[2:1] != 2'b00 || ack[2:1] != 2'b00) bad++;
            if (mem_read_en) wbad++;
            if (mem_write_en) begin
                wen++;
                last_wen = c;
                if (mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) wbad++;
            end
            if (c == 1) begin
                checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL boot_first_grant: got grant=%b busy=%b expected 001 1", grant, busy); end
            end
            if (ack[0]) begin
                acks++;
                ack_cyc = c;
                req[0] = 1'b0;
            end
        end
        checks++; if (wen != AC) begin errors++; $display("FAIL boot_wen_cycles: got %0d expected %0d", wen, AC); end
        checks++; if (last_wen != AC) begin errors++; $display("FAIL boot_wen_last: got %0d expected %0d", last_wen, AC); end
        checks++; if (wbad != 0) begin errors++; $display("FAIL boot_mem_bus: got %0d bad cycles expected 0", wbad); end
        checks++; if (acks != 1 || ack_cyc != AC + 1) begin errors++; $display("FAIL boot_ack: got %0d acks at cycle %0d expected 1 at %0d", acks, ack_cyc, AC + 1); end
        checks++; if (bad != 0) begin errors++; $display("FAIL boot_exclusive: got %0d cycles granting 1/2 expected 0", bad); end
        checks++; if (busy !== 1'b0 || grant !== 3'b000) begin errors++; $display("FAIL boot_idle: got busy=%b grant=%b expected 0 000", busy, grant); end
        req = 3'b000;
    endtask

    task automatic test_core_read();
        int ren = 0;
        int ack_cyc = -1;
        boot_mode = 1'b0;
        set_port(1, 1'b0, 16'h0010, 16'h0000);
        req = 3'b010;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (mem_read_en) ren++;
            if (ack != 3'b000) begin
                ack_cyc = c;
                checks++; if (ack !== 3'b010) begin errors++; $display("FAIL read_ack_owner: got %b expected 010", ack); end
                checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata: got %h expected beef", rdata); end
                req[1] = 1'b0;
            end
        end
        checks++; if (ren != AC) begin errors++; $display("FAIL read_ren_cycles: got %0d expected %0d", ren, AC); end
        checks++; if (ack_cyc != AC + 1) begin errors++; $display("FAIL read_ack_cycle: got %0d expected %0d", ack_cyc, AC + 1); end
        tick();
        tick();
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL read_rdata_hold: got %h expected beef", rdata); end
        set_port(0, 1'b1, 16'h0020, 16'h1234);
        req = 3'b001;
        ack_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ack[0]) begin
                ack_cyc = c;
                req[0] = 1'b0;
            end
        end
        checks++; if (ack_cyc != AC + 1) begin errors++; $display("FAIL write_ack_cycle: got %0d expected %0d", ack_cyc, AC + 1); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("FAIL write_keeps_rdata: got %h expected beef", rdata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_seq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [2:0] seq [6];
        int cyc [6];
        int n = 0;
        int acks = 0;
        int ackbad = 0;
        logic [2:0] prev;
        rst = 1'b0;
        boot_mode = 1'b0;
        set_port(0, 1'b0, 16'h0040, 16'h0000);
        set_port(1, 1'b0, 16'h0041, 16'h0000);
        set_port(2, 1'b0, 16'h0042, 16'h0000);
        req = 3'b111;
        tick();
        tick();
        rst = 1'b1;
        prev = grant;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (grant != 3'b000 && prev == 3'b000) begin
                if (n < 6) begin
                    seq[n] = grant;
                    cyc[n] = c;
                end
                n++;
            end
            if (ack != 3'b000) begin
                acks++;
                if (ack !== grant) ackbad++;
            end
            prev = grant;
        end
        req = 3'b000;
        checks++; if (n != 6) begin errors++; $display("FAIL rr_grant_count: got %0d expected 6", n); end
        for (int i = 0; i < 6 && i < n; i++) begin
            checks++; if (seq[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, seq[i], exp_seq[i]); end
        end
        checks++; if (n >= 1 && cyc[0] != 1) begin errors++; $display("FAIL rr_first_cycle: got %0d expected 1", cyc[0]); end
        for (int i = 1; i < 6 && i < n; i++) begin
            checks++; if (cyc[i] - cyc[i-1] != AC + 2) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", i, cyc[i] - cyc[i-1], AC + 2); end
        end
        checks++; if (acks != 6 || ackbad != 0) begin errors++; $display("FAIL rr_acks: got %0d acks, %0d off-owner expected 6, 0", acks, ackbad); end
    endtask

    task automatic test_reset_abort();
        int rst_acks = 0;
        int g_n = 0;
        logic [2:0] g [2];
        int g_cyc [2];
        logic [2:0] prev;
        set_port(0, 1'b1, 16'h0050, 16'hA5A5);
        set_port(1, 1'b0, 16'h0051, 16'h0000);
        req = 3'b001;
        tick();
        checks++; if (grant !== 3'b001 || mem_write_en !== 1'b1) begin errors++; $display("FAIL abort_setup: got grant=%b wr=%b expected 001 1", grant, mem_write_en); end
        tick();
        #2 rst = 1'b0;
        #1;
        checks++; if (mem_write_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %b expected 0", mem_write_en); end
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin errors++; $display("FAIL abort_grant_busy: got grant=%b busy=%b expected 000 0", grant, busy); end
        req = 3'b011;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (ack != 3'b000) rst_acks++;
        end
        rst = 1'b1;
        prev = grant;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (ack != 3'b000 && c < AC + 1) rst_acks++;
            if (grant != 3'b000 && prev == 3'b000 && g_n < 2) begin
                g[g_n] = grant;
                g_cyc[g_n] = c;
                g_n++;
            end
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
            prev = grant;
        end
        checks++; if (rst_acks != 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks expected 0", rst_acks); end
        checks++; if (g_n != 2) begin errors++; $display("FAIL abort_grant_count: got %0d expected 2", g_n); end
        if (g_n == 2) begin
            checks++; if (g[0] !== 3'b001 || g_cyc[0] != 1) begin errors++; $display("FAIL abort_first_grant: got %b at %0d expected 001 at 1", g[0], g_cyc[0]); end
            checks++; if (g[1] !== 3'b010 || g_cyc[1] != AC + 3) begin errors++; $display("FAIL abort_second_grant: got %b at %0d expected 010 at %0d", g[1], g_cyc[1], AC + 3); end
        end
        req = 3'b000;
    endtask

    task automatic test_boot_release();
        int ack_cyc = -1;
        int next_cyc = -1;
        logic [2:0] next_g = 3'b000;
        logic [2:0] ack_seen = 3'b000;
        boot_mode = 1'b1;
        set_port(0, 1'b1, 16'h0060, 16'h0F0F);
        set_port(1, 1'b0, 16'h0061, 16'h0000);
        set_port(2, 1'b0, 16'h0062, 16'h0000);
        req = 3'b111;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                checks++; if (grant !== 3'b001) begin errors++; $display("FAIL brel_first_grant: got %b expected 001", grant); end
            end
            if (c == 2) boot_mode = 1'b0;
            if (ack_cyc < 0 && ack != 3'b000) begin
                ack_cyc = c;
                ack_seen = ack;
            end
            if (ack_cyc > 0 && next_cyc < 0 && c > ack_cyc && grant != 3'b000) begin
                next_cyc = c;
                next_g = grant;
            end
            if (ack[0]) req[0] = 1'b0;
            if (ack[1]) req[1] = 1'b0;
        end
        req = 3'b000;
        checks++; if (ack_seen !== 3'b001 || ack_cyc != AC + 1) begin errors++; $display("FAIL brel_ack: got %b at %0d expected 001 at %0d", ack_seen, ack_cyc, AC + 1); end
        checks++; if (next_g !== 3'b010 || next_cyc != AC + 3) begin errors++; $display("FAIL brel_next_grant: got %b at %0d expected 010 at %0d", next_g, next_cyc, AC + 3); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int acks = 0;
        int cyc [3];
        logic [2:0] prev;
        set_port(2, 1'b0, 16'h0077, 16'h0000);
        req = 3'b100;
        prev = grant;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (grant != 3'b000 && prev == 3'b000) begin
                if (n < 3) cyc[n] = c;
                n++;
            end
            if (ack != 3'b000) begin
                acks++;
                checks++; if (ack !== 3'b100) begin errors++; $display("FAIL b2b_ack_owner: got %b expected 100", ack); end
                checks++; if (rdata !== 16'h5A2D) begin errors++; $display("FAIL b2b_rdata: got %h expected 5a2d", rdata); end
                req[2] = 1'b0;
            end else if (!req[2]) begin
                req[2] = 1'b1;
            end
            prev = grant;
        end
        req = 3'b000;
        checks++; if (n != 3 || acks != 3) begin errors++; $display("FAIL b2b_counts: got %0d grants %0d acks expected 3 3", n, acks); end
        for (int i = 1; i < 3 && i < n; i++) begin
            checks++; if (cyc[i] - cyc[i-1] != AC + 2) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, cyc[i] - cyc[i-1], AC + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_boot_mode();
        test_core_read();
        test_round_robin();
        test_reset_abort();
        test_boot_release();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single memory_controller port between several bus masters: the program loader, the control_unit core, and a spare debug/DMA port. It replaces hard muxing on the boot signal with a round-robin arbiter. A boot_mode input restricts access to requester 0 while the loader owns memory. Each access is sequenced as one read or write with a fixed hold time, and the requester gets a one-cycle acknowledge when it completes.

Parameters:
NREQ, 3, number of requesters; index 0 = loader, 1 = core, 2 = debug; must be 2..8
ACCESS_CYCLES, 4, clk cycles that address, data and enable are held to memory_controller; must be >= 1
AW, 16, address width
DW, 16, data width

Ports:
clk  input  1  global clock (50 MHz domain)
rst  input  1  asynchronous, active-low reset
boot_mode  input  1  1 = only requester 0 is eligible
req  input  NREQ  per-requester access request, level
we  input  NREQ  per-requester write flag (1 = write), valid while req is high
addr  input  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
wdata  input  NREQ*DW  packed write data, same packing as addr
ack  output  NREQ  one-cycle completion pulse to the granted requester
grant  output  NREQ  one-hot owner during ACCESS and ACK
rdata  output  DW  read data returned to the requester
busy  output  1  high in ACCESS and ACK
mem_addr  output  AW  to memory_controller
mem_wdata  output  DW  to memory_controller
mem_rdata  input  DW  from memory_controller
mem_read_en  output  1  to memory_controller
mem_write_en  output  1  to memory_controller

Behaviour:
- States: IDLE, ACCESS, ACK. Reset state is IDLE.
- Reset (rst=0, asynchronous, including mid-access):
  - ack, grant, busy, mem_read_en, mem_write_en, mem_addr, mem_wdata, rdata all go to 0.
  - Round-robin pointer last goes to NREQ-1.
  - Any in-flight access is aborted and never acknowledged.
- Eligibility: eligible = req & (boot_mode ? 1 : all-ones), i.e. only req[0] when boot_mode=1.
- IDLE:
  - If eligible != 0 at a clock edge, pick the first eligible index searching last+1, last+2, ... modulo NREQ.
  - At that edge: set last = g, grant = onehot(g), latch addr/we/wdata of g into mem_addr/mem_wdata, set mem_write_en = we[g] and mem_read_en = ~we[g], load counter = ACCESS_CYCLES-1, go to ACCESS.
  - If eligible == 0, stay in IDLE with all enables 0.
- ACCESS:
  - Lasts exactly ACCESS_CYCLES cycles; mem_addr, mem_wdata and the enable are stable throughout.
  - Counter decrements each cycle. At the edge where counter == 0:
    - for a read, register mem_rdata into rdata;
    - drop both enables, go to ACK.
- ACK:
  - Exactly one cycle: ack[g] = 1, grant is held, then go to IDLE.
  - grant, ack and busy clear on the edge leaving ACK.
- Latency: req sampled at IDLE edge E0 -> ack high during cycle ACCESS_CYCLES+1 after E0 -> next grant no earlier than edge E0+ACCESS_CYCLES+2. One access per ACCESS_CYCLES+2 cycles maximum.
- Requester contract: hold req/we/addr/wdata until ack is seen, and drop req at the edge ending the ack cycle. A requester may re-raise req immediately; it is then arbitrated normally, so other waiters get served first.
- req changes during ACCESS/ACK are ignored; the latched request completes.
- rdata is valid in the ack cycle and holds until the next read completes. Writes never modify rdata.
- boot_mode toggling mid-access does not abort the access; it only affects the next IDLE decision.
- Round-robin fairness: with all NREQ requesting continuously, the grant order is 0,1,2,0,1,2... from reset. No requester waits more than NREQ-1 accesses.
- Deasserted req in IDLE is never granted; zero-requester idle draws no memory enables.

Test Plan:
- Reset, boot_mode=1, req=3'b111, req[0] write addr 0x0010 data 0xBEEF, ACCESS_CYCLES=4 -> only index 0 granted; mem_write_en high exactly 4 cycles with mem_addr=0x0010; ack[0] one cycle later; req[1]/req[2] never granted while boot_mode=1.
- boot_mode=0, core reads 0x0010 with mem_rdata model returning 0xBEEF -> mem_read_en high 4 cycles; rdata=0xBEEF in ack[1] cycle and held afterwards; a following write leaves rdata=0xBEEF.
- All three requesters continuously requesting from reset -> grant sequence 0,1,2,0,1,2; accesses spaced 6 cycles apart; exactly one ack per access.
- Pull rst low during the 2nd ACCESS cycle of a write -> mem_write_en, grant and busy go to 0 immediately (asynchronously); no ack; after release with req[1] high, index 0 is checked first (last=NREQ-1) and requester 1 is granted.
- boot_mode goes 1->0 mid-access with req=3'b110 pending -> current loader access completes with ack[0]; next grant is to requester 1.
- Single requester with req toggling low for one cycle between accesses -> back-to-back service at a 6-cycle period; no duplicate ack.
